// File: rtl/sram_mbist_ctrl.sv
// March C- memory BIST sequencer that owns the single-port SRAM port while busy.
// Latency: first op two edges after start is sampled, result 10*2**ADDR_W+2 edges after start.
// Backpressure: none; SRAM is driven one op per cycle, bist_en low aborts, dft_en forces idle.
//
// Ports:
//   hclk, hresetn        clock, async active-low reset
//   bist_en, dft_en      run request (level), scan-mode override
//   sram_rdata           SRAM read data, valid the cycle after a read strobe
//   bist_busy            SRAM mux select (RUN/DRAIN only)
//   bist_done, bist_fail pass complete / sticky mismatch, held until bist_en falls
//   sram_cs/we/addr/wdata SRAM command port
//   fail_addr, fail_elem address and March element of the first mismatch
module sram_mbist_ctrl #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              bist_en,
    input  logic              dft_en,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_fail,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [DATA_W-1:0] D0        = '0;
    localparam logic [DATA_W-1:0] D1        = '1;

    logic [1:0]        state, state_nxt;
    logic [2:0]        elem;        // element of the next op to issue
    logic [ADDR_W-1:0] addr;        // address of the next op to issue
    logic              phase;       // 0 = read half, 1 = write half of a two-op element
    logic [2:0]        elem_nxt;

    logic              op_single, op_rd, op_wr_d1, elem_down, op_last, elem_last, run_last;
    logic [ADDR_W-1:0] end_addr;
    logic              issue, leave;

    // Element tag of the op currently on the SRAM port, and the compare stage
    // that lines a read up with the data returned one cycle later.
    logic [2:0]        op_elem;
    logic              cmp_vld;
    logic [ADDR_W-1:0] cmp_addr;
    logic [2:0]        cmp_elem;
    logic [DATA_W-1:0] cmp_exp;
    logic              mismatch;

    // ---------------- op decode for the next issue ----------------
    assign op_single = (elem == M0) || (elem == M5);
    assign op_rd     = (elem != M0) && (op_single || !phase);
    assign op_wr_d1  = (elem == M1) || (elem == M3);
    assign elem_down = (elem >= M3);
    assign end_addr  = elem_down ? ADDR_ZERO : ADDR_LAST;
    assign op_last   = op_single || phase;
    assign elem_last = op_last && (addr == end_addr);
    assign run_last  = elem_last && (elem == M5);
    assign elem_nxt  = elem + 3'd1;

    // dft_en beats everything; bist_en low always heads back to IDLE.
    always_comb begin
        state_nxt = state;
        if (dft_en || !bist_en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_RUN;
                ST_RUN:   state_nxt = run_last ? ST_DRAIN : ST_RUN;
                ST_DRAIN: state_nxt = ST_DONE;
                default:  state_nxt = ST_DONE;
            endcase
        end
    end

    assign issue = (state == ST_RUN) && (state_nxt != ST_IDLE);
    assign leave = (state != ST_IDLE) && (state_nxt == ST_IDLE);

    // ---------------- state and March counters ----------------
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= ST_IDLE;
            elem  <= M0;
            addr  <= ADDR_ZERO;
            phase <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE) begin
                elem  <= M0;
                addr  <= ADDR_ZERO;
                phase <= 1'b0;
            end else if (issue) begin
                if (!op_last) begin
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (elem_last) begin
                        // M2 -> M3 keeps N-1; other boundaries wrap, so load explicitly.
                        elem <= elem_nxt;
                        addr <= (elem_nxt >= M3) ? ADDR_LAST : ADDR_ZERO;
                    end else begin
                        addr <= elem_down ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
                    end
                end
            end
        end
    end

    // ---------------- registered SRAM port and status ----------------
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            bist_busy  <= 1'b0;
            bist_done  <= 1'b0;
            sram_cs    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= ADDR_ZERO;
            sram_wdata <= D0;
            op_elem    <= M0;
        end else if (leave) begin
            bist_busy  <= 1'b0;
            bist_done  <= 1'b0;
            sram_cs    <= 1'b0;
            sram_we    <= 1'b0;
            sram_wdata <= D0;
        end else begin
            bist_busy  <= (state == ST_RUN) || (state == ST_DRAIN);
            bist_done  <= (state == ST_DONE);
            sram_cs    <= issue;
            sram_we    <= issue && !op_rd;
            sram_wdata <= (issue && !op_rd && op_wr_d1) ? D1 : D0;
            // Address is left alone when idle so the SRAM pins stay quiet.
            if (issue) begin
                sram_addr <= addr;
                op_elem   <= elem;
            end
        end
    end

    // ---------------- read compare and first-failure latch ----------------
    assign cmp_exp  = ((cmp_elem == M2) || (cmp_elem == M4)) ? D1 : D0;
    assign mismatch = cmp_vld && (sram_rdata != cmp_exp);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cmp_vld   <= 1'b0;
            cmp_addr  <= ADDR_ZERO;
            cmp_elem  <= M0;
            bist_fail <= 1'b0;
            fail_addr <= ADDR_ZERO;
            fail_elem <= M0;
        end else if (leave) begin
            // Abort or result release: drop in-flight compares with the result.
            cmp_vld   <= 1'b0;
            bist_fail <= 1'b0;
            fail_addr <= ADDR_ZERO;
            fail_elem <= M0;
        end else begin
            cmp_vld  <= sram_cs && !sram_we;
            cmp_addr <= sram_addr;
            cmp_elem <= op_elem;
            if (mismatch && !bist_fail) begin
                bist_fail <= 1'b1;
                fail_addr <= cmp_addr;
                fail_elem <= cmp_elem;
            end
        end
    end

endmodule

// File: doc/sram_mbist_ctrl.md
# sram_mbist_ctrl

Memory built-in self-test sequencer for the single-port SRAM behind the AHB SRAM controller. When `bist_en` is asserted it takes over the SRAM port and runs a March C- pass over every address. It reports `bist_done`/`bist_fail`, which connect to the sramc wrapper's `bist_done`/`bist_fail` outputs. While `bist_busy` is high, the SRAM-side mux in the sramc wrapper selects this block instead of the AHB datapath.

## Interface
- `ADDR_W`, 13, SRAM word address width; depth N = 2**ADDR_W.
- `DATA_W`, 32, SRAM word width.
- `hclk` in 1: system clock, all flops on rising edge.
- `hresetn` in 1: asynchronous, active-low reset.
- `bist_en` in 1: level request to run/hold BIST.
- `dft_en` in 1: scan mode; forces IDLE and blocks start.
- `sram_rdata` in DATA_W: SRAM read data, valid one cycle after a read strobe.
- `bist_busy` out 1: block owns the SRAM port (mux select).
- `bist_done` out 1: pass complete, held until `bist_en` falls.
- `bist_fail` out 1: sticky mismatch flag, meaningful with `bist_done`.
- `sram_cs` out 1: SRAM chip select.
- `sram_we` out 1: write enable (1 = write).
- `sram_addr` out ADDR_W: SRAM address.
- `sram_wdata` out DATA_W: SRAM write data.
- `fail_addr` out ADDR_W: address of the first mismatch.
- `fail_elem` out 3: March element index (0–5) of the first mismatch.

## Operation
- States:
  - IDLE: entered on reset.
  - RUN: executes elements M0–M5.
  - DRAIN: one cycle for the final compare.
  - DONE: result held.
- The transition `dft_en`=1 → IDLE has priority over all other transitions.
- IDLE → RUN when `bist_en`=1 and `dft_en`=0 at a clock edge. The element counter, address and op phase are initialised to M0, address 0, op 0.
- March C- elements. D0 = all zeros, D1 = all ones. ↑ = address 0 → N-1, ↓ = address N-1 → 0.
  - M0 ↑(w0)
  - M1 ↑(r0,w1)
  - M2 ↑(r1,w0)
  - M3 ↓(r0,w1)
  - M4 ↓(r1,w0)
  - M5 ↓(r0)
- One SRAM operation per cycle with no idle cycles between elements. Ops per element: M0 and M5 N each; M1–M4 2N each; total 10N.
- Two-op elements issue r then w at the same address, then advance the address.
- The address counter is ADDR_W bits and wraps.
  - ↑ elements end when address N-1 is done.
  - ↓ elements start at N-1 and end at 0.
- Compare: `sram_rdata` is checked against the expected word one cycle after each read.
  - On a mismatch with `bist_fail`=0: set `bist_fail`, latch `fail_addr` and `fail_elem` from a one-stage pipeline of the read's address and element.
  - Later mismatches do not change the latches.
- The test always runs to completion on failure; there is no early abort.
- RUN → DRAIN after the last M5 read (address 0) is issued. DRAIN → DONE.
- DONE → IDLE when `bist_en`=0. On that transition, clear `bist_done`, `bist_fail`, `fail_addr` and `fail_elem`.
- `bist_en`=0 during RUN/DRAIN aborts the test: go to IDLE next edge, drop `bist_busy`, `sram_cs` and `sram_we`, and leave `bist_done`=0 and `bist_fail`=0.
- `bist_busy` = 1 in RUN and DRAIN only, and 0 in DONE. This returns the SRAM to AHB while the result is held.

## Timing
- Reset value of every output is 0.
- All outputs are registered; there is no combinational path from any input to any output.
- Edge E0 samples `bist_en`=1 in IDLE.
- Op j (0 ≤ j < 10N) is driven on `sram_cs`/`sram_we`/`sram_addr`/`sram_wdata` between E(j+1) and E(j+2).
- `bist_busy` rises after E1.
- `sram_cs`=1 continuously for 10N cycles, then falls in DRAIN.
- `bist_done` and the final `bist_fail` are visible after E(10N+2). For ADDR_W=4 that is E162.
- `sram_wdata` = 0 during reads.
- `sram_addr` holds its last value when `sram_cs`=0.
- Reset asserted mid-run: every output clears immediately (asynchronously) and the state returns to IDLE.

## Test plan
- Good SRAM model, ADDR_W=4, `bist_en` raised and held → `bist_busy` high for exactly 161 cycles, `bist_done`=1 and `bist_fail`=0 after E162, exactly 160 ops with `sram_cs`=1.
- Stuck-at-1 on bit 5 at address 0x9 → `bist_fail`=1, `fail_addr`=0x9, `fail_elem`=1 (first r0 of M1), and `bist_done` still rises after E162.
- Coupling fault: write to 0x3 flips 0x4 bit 0 only in the ↓ direction → first mismatch reported with `fail_elem`=3 or 4 and `fail_addr`=0x4; the op sequence checked against a scoreboard (order r/w, addresses, D0/D1).
- `bist_en` dropped at op 50 → IDLE next edge, `bist_busy`=0, `bist_done`=0, `bist_fail`=0; re-raising it restarts at M0 address 0.
- `dft_en`=1 during RUN, then `dft_en`=1 with `bist_en`=1 in IDLE → forced to IDLE, and no start while `dft_en`=1.
- `hresetn` pulsed low mid-M3 → all outputs 0 asynchronously; after release with `bist_en` still high, a full pass completes.
- After DONE, dropping `bist_en` → `bist_done`/`bist_fail`/`fail_addr` cleared after one edge.
